// File: rtl/toggle_counter_pkg.sv
// Shared encodings for the multi-channel toggle counter: per-channel FSM state
// and terminal-value behaviour selection.
package toggle_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/toggle_channel.sv
// One channel: start/stop toggle FSM with a Mealy count enable, driving an
// up/down counter bounded by MAX that either wraps or saturates and stops.
module toggle_channel
    import toggle_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             toggle,
    input  logic             down,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
    localparam bit               SAT   = (SATURATE == MODE_SAT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             en;

    // A start request counts on the same edge; a stop request does not.
    assign en = ((state_q == ST_IDLE) &&  toggle) ||
                ((state_q == ST_RUN)  && !toggle);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;

        if (toggle) begin
            state_d = (state_q == ST_IDLE) ? ST_RUN : ST_IDLE;
        end

        if (clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (en) begin
            if (!down) begin
                if (count_q == MAX_V) begin
                    tc_d = 1'b1;
                    if (SAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + ONE_V;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (SAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        count_d = MAX_V;
                    end
                end else begin
                    count_d = count_q - ONE_V;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == ST_RUN);
    assign tc      = tc_q;

endmodule

// File: rtl/toggle_counter_mc.sv
// Multi-channel toggle counter: CHANNELS independent toggle_channel instances
// with their counts packed onto one bus, channel i at [i*WIDTH +: WIDTH].
module toggle_counter_mc
    import toggle_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int MAX      = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       toggle,
    input  logic [CHANNELS-1:0]       down,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       running,
    output logic [CHANNELS-1:0]       tc
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        toggle_channel #(
            .WIDTH    (WIDTH),
            .MAX      (MAX),
            .SATURATE (SATURATE)
        ) u_ch (
            .clock   (clock),
            .rst_n   (rst_n),
            .toggle  (toggle[i]),
            .down    (down[i]),
            .clear   (clear[i]),
            .count   (count[i*WIDTH +: WIDTH]),
            .running (running[i]),
            .tc      (tc[i])
        );
    end

endmodule
